// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared divider op and state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } state_t;

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// Module      : div_step
// Description : One combinational radix-2 restoring division iteration.
// Revision    : 1.0 - initial release
// ============================================================================
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0]   w_shift;
    logic [WIDTH+1:0] w_diff;
    logic             w_borrow;

    always_comb begin
        w_shift  = {rem_i, quo_i[WIDTH-1]};
        // Extra top bit turns the subtract into a borrow flag
        w_diff   = {1'b0, w_shift} - {2'b00, divisor_i};
        w_borrow = w_diff[WIDTH+1];
        rem_o    = WIDTH'(w_borrow ? w_shift : w_diff[WIDTH:0]);
        quo_o    = {quo_i[WIDTH-2:0], ~w_borrow};
    end

endmodule
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module      : div_unit
// Description : Iterative RV32M DIV/DIVU/REM/REMU divider with valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module div_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out
);

    localparam logic [WIDTH-1:0] c_INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] c_LAST    = CNT_W'(WIDTH-1);

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] babs_q, babs_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             qsign_q, qsign_d;
    logic             rsign_q, rsign_d;

    logic             w_signed;
    logic [WIDTH-1:0] w_a_abs;
    logic [WIDTH-1:0] w_b_abs;
    logic [WIDTH-1:0] w_step_rem;
    logic [WIDTH-1:0] w_step_quo;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (babs_q),
        .rem_o     (w_step_rem),
        .quo_o     (w_step_quo)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            babs_q  <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            out_q   <= '0;
            cnt_q   <= '0;
            qsign_q <= 1'b0;
            rsign_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            babs_q  <= babs_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
            qsign_q <= qsign_d;
            rsign_q <= rsign_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        babs_d  = babs_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        out_d   = out_q;
        cnt_d   = cnt_q;
        qsign_d = qsign_q;
        rsign_d = rsign_q;

        // op[0] clear selects the signed variants
        w_signed = ~op[0];
        w_a_abs  = (w_signed && a[WIDTH-1]) ? -a : a;
        w_b_abs  = (w_signed && b[WIDTH-1]) ? -b : b;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_d    = op;
                    babs_d  = w_b_abs;
                    qsign_d = w_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                    rsign_d = w_signed & a[WIDTH-1];
                    if (b == '0) begin
                        out_d   = op[1] ? a : '1;
                        state_d = S_DONE;
                    end else if (w_signed && (a == c_INT_MIN) && (b == '1)) begin
                        out_d   = op[1] ? '0 : c_INT_MIN;
                        state_d = S_DONE;
                    end else begin
                        rem_d   = '0;
                        quo_d   = w_a_abs;
                        cnt_d   = '0;
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                rem_d = w_step_rem;
                quo_d = w_step_quo;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == c_LAST) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (op_q[1]) begin
                    out_d = rsign_q ? -rem_q : rem_q;
                end else begin
                    out_d = qsign_q ? -quo_q : quo_q;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign out       = out_q;

endmodule
`default_nettype wire
